instr_encoder: RTL and testbench

Sequential MIPS instruction encoder for the minisys single-cycle CPU: accepts one symbolic instruction per handshake (mnemonic ID plus register/immediate fields), packs it into the 32-bit MIPS word format that the control decoder consumes, and writes it to consecutive instruction-memory words. It is the program-load path in front of instruction memory. It emits every opcode/funct combination the control decoder recognises, plus an optional two-word LI pseudo-op.

---
 rtl/instr_encoder.sv | 198 +++++++++++++++++++
 tb/tb_instr_encoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Sequential MIPS instruction encoder: packs one symbolic instruction per handshake into
// consecutive instruction-memory words. Define PSEUDO_LI_EN to enable the two-word LI pseudo-op.
module instr_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              err,
    output logic              full,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W:0]   CAP  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    logic [ADDR_W:0]   r_count;
    logic              r_we;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    logic [5:0]        w_funct;
    logic [5:0]        w_opcode;
    logic              w_shift;
    logic [31:0]       w_enc;
    logic              w_reserved;
    logic              w_emit2;
    logic              w_is_li;
    logic              w_li_ok;
    logic              w_accept;
    logic [31:0]       w_lui;
    logic [31:0]       w_pending_word;
    logic [ADDR_W-1:0] w_addr;

    assign w_addr = BASE + r_count[ADDR_W-1:0];

    // Single-word encoder for every non-LI mnemonic.
    always_comb begin
        w_funct = 6'h00;
        case (in_op)
            5'd0:  w_funct = 6'h20;
            5'd1:  w_funct = 6'h21;
            5'd2:  w_funct = 6'h22;
            5'd3:  w_funct = 6'h23;
            5'd4:  w_funct = 6'h24;
            5'd5:  w_funct = 6'h25;
            5'd6:  w_funct = 6'h26;
            5'd7:  w_funct = 6'h27;
            5'd8:  w_funct = 6'h2A;
            5'd9:  w_funct = 6'h2B;
            5'd10: w_funct = 6'h00;
            5'd11: w_funct = 6'h02;
            5'd12: w_funct = 6'h03;
            5'd13: w_funct = 6'h04;
            5'd14: w_funct = 6'h06;
            5'd15: w_funct = 6'h07;
            5'd16: w_funct = 6'h08;
            default: w_funct = 6'h00;
        endcase
        w_opcode = 6'h00;
        case (in_op)
            5'd17: w_opcode = 6'h08;
            5'd18: w_opcode = 6'h09;
            5'd19: w_opcode = 6'h0C;
            5'd20: w_opcode = 6'h0D;
            5'd21: w_opcode = 6'h0E;
            5'd22: w_opcode = 6'h23;
            5'd23: w_opcode = 6'h2B;
            5'd24: w_opcode = 6'h04;
            5'd25: w_opcode = 6'h05;
            5'd26: w_opcode = 6'h0F;
            5'd27: w_opcode = 6'h0A;
            5'd28: w_opcode = 6'h0B;
            default: w_opcode = 6'h00;
        endcase
        w_shift    = (in_op >= 5'd10) && (in_op <= 5'd12);
        w_enc      = 32'h0;
        w_reserved = 1'b0;
        if (in_op <= 5'd16) begin
            w_enc = {6'b000000,
                     w_shift ? 5'd0 : in_rs,
                     (in_op == 5'd16) ? 5'd0 : in_rt,
                     (in_op == 5'd16) ? 5'd0 : in_rd,
                     w_shift ? in_shamt : 5'd0,
                     w_funct};
        end else if (in_op <= 5'd28) begin
            w_enc = {w_opcode, (in_op == 5'd26) ? 5'd0 : in_rs, in_rt, in_imm[15:0]};
        end else if (in_op == 5'd29) begin
            w_enc = {6'b000010, in_imm[25:0]};
        end else begin
            w_reserved = !w_is_li;
        end
    end

`ifdef PSEUDO_LI_EN
    typedef enum logic {S_IDLE = 1'b0, S_EMIT2 = 1'b1} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [31:0]       r_ori;
    logic [ADDR_W:0]   w_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (clear)
            w_state_next = S_IDLE;
        else if (r_state == S_EMIT2)
            w_state_next = S_IDLE;
        else if (w_accept && w_is_li && w_li_ok)
            w_state_next = S_EMIT2;
    end

    assign w_emit2        = (r_state == S_EMIT2);
    assign w_is_li        = (in_op == 5'd30);
    assign w_free         = CAP - r_count;
    assign w_li_ok        = (w_free >= {{(ADDR_W-1){1'b0}}, 2'd2});
    assign w_lui          = {6'b001111, 5'd0, in_rt, in_imm[31:16]};
    assign w_pending_word = r_ori;

    // ORI half is captured at accept time so the inputs are free during EMIT2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ori <= 32'h0;
        else if (w_accept && w_is_li)
            r_ori <= {6'b001101, in_rt, in_rt, in_imm[15:0]};
    end
`else
    logic w_unused;
    assign w_unused       = &{1'b0, in_imm[31:26]};
    assign w_emit2        = 1'b0;
    assign w_is_li        = 1'b0;
    assign w_li_ok        = 1'b0;
    assign w_lui          = 32'h0;
    assign w_pending_word = 32'h0;
`endif

    always_comb begin
        in_ready = !w_emit2 && !full && !clear;
        w_accept = in_valid && in_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= BASE;
            r_wdata <= 32'h0;
        end else begin
            r_we  <= 1'b0;
            r_err <= 1'b0;
            if (clear) begin
                r_count <= '0;
            end else if (w_emit2) begin
                r_we    <= 1'b1;
                r_addr  <= w_addr;
                r_wdata <= w_pending_word;
                r_count <= r_count + ONE;
            end else if (w_accept) begin
                if (w_reserved || (w_is_li && !w_li_ok)) begin
                    r_err <= 1'b1;
                end else begin
                    r_we    <= 1'b1;
                    r_addr  <= w_addr;
                    r_wdata <= w_is_li ? w_lui : w_enc;
                    r_count <= r_count + ONE;
                end
            end
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign err        = r_err;
    assign word_count = r_count;
    assign full       = (r_count == CAP);

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a 1024-word and a 4-word instance share one
// stimulus stream; a table-driven model predicts every output on every cycle.
module tb_instr_encoder;

`ifdef PSEUDO_LI_EN
    localparam bit LI_EN = 1'b1;
`else
    localparam bit LI_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [4:0]  in_op = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [31:0] in_imm = '0;

    logic        rdy[2], we[2], err_o[2], full_o[2];
    logic [31:0] wd[2];
    logic [9:0]  addr_b;
    logic [1:0]  addr_s;
    logic [10:0] wc_b;
    logic [2:0]  wc_s;
    logic [31:0] act_addr[2], act_wc[2];

    assign act_addr[0] = 32'(addr_b);
    assign act_addr[1] = 32'(addr_s);
    assign act_wc[0]   = 32'(wc_b);
    assign act_wc[1]   = 32'(wc_s);

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) u_big (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .imem_we(we[0]), .imem_addr(addr_b), .imem_wdata(wd[0]),
        .err(err_o[0]), .full(full_o[0]), .word_count(wc_b)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) u_small (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .imem_we(we[1]), .imem_addr(addr_s), .imem_wdata(wd[1]),
        .err(err_o[1]), .full(full_o[1]), .word_count(wc_s)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d: got %h, expected %h (t=%0t)", name, k, act, exp, $time);
        end
    endtask

    // Encoding tables indexed by mnemonic ID.
    logic [5:0] funct_t [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};
    logic [5:0] opc_t [12]   = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B,
                                 6'h04, 6'h05, 6'h0F, 6'h0A, 6'h0B};

    function automatic logic [31:0] enc(input int op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [31:0] imm);
        bit shift = (op >= 10 && op <= 12);
        if (op <= 16)
            return {6'b0, shift ? 5'd0 : rs, (op == 16) ? 5'd0 : rt, (op == 16) ? 5'd0 : rd,
                    shift ? sh : 5'd0, funct_t[op]};
        if (op <= 28)
            return {opc_t[op-17], (op == 26) ? 5'd0 : rs, rt, imm[15:0]};
        return {6'b000010, imm[25:0]};
    endfunction

    // Model state per instance: words written, pending ORI, expected registered outputs.
    int          cap[2] = '{1024, 4};
    int          cnt[2] = '{0, 0};
    bit          pend[2] = '{1'b0, 1'b0};
    logic [31:0] pw[2] = '{32'h0, 32'h0};
    bit          exp_we[2] = '{1'b0, 1'b0};
    int          exp_addr[2] = '{0, 0};
    logic [31:0] exp_wd[2] = '{32'h0, 32'h0};
    bit          exp_err[2] = '{1'b0, 1'b0};
    bit          m_rdy;

    task automatic model_write(input int k, input logic [31:0] w);
        exp_we[k]   = 1'b1;
        exp_addr[k] = cnt[k] % cap[k];
        exp_wd[k]   = w;
        cnt[k]++;
    endtask

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                cnt[k] = 0; pend[k] = 1'b0; exp_we[k] = 1'b0; exp_addr[k] = 0;
                exp_wd[k] = 32'h0; exp_err[k] = 1'b0;
            end else begin
                m_rdy = !pend[k] && cnt[k] < cap[k] && !clear;
                exp_we[k]  = 1'b0;
                exp_err[k] = 1'b0;
                if (clear) begin
                    cnt[k] = 0;
                    pend[k] = 1'b0;
                end else if (pend[k]) begin
                    model_write(k, pw[k]);
                    pend[k] = 1'b0;
                end else if (in_valid && m_rdy) begin
                    if (in_op == 5'd31 || (in_op == 5'd30 && !LI_EN)) begin
                        exp_err[k] = 1'b1;
                    end else if (in_op == 5'd30) begin
                        if (cap[k] - cnt[k] < 2) begin
                            exp_err[k] = 1'b1;
                        end else begin
                            model_write(k, enc(26, 5'd0, in_rt, 5'd0, 5'd0, {16'h0, in_imm[31:16]}));
                            pend[k] = 1'b1;
                            pw[k] = enc(20, in_rt, in_rt, 5'd0, 5'd0, {16'h0, in_imm[15:0]});
                        end
                    end else begin
                        model_write(k, enc(int'(in_op), in_rs, in_rt, in_rd, in_shamt, in_imm));
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check("in_ready", k, {31'b0, rdy[k]}, {31'b0, !pend[k] && cnt[k] < cap[k] && !clear});
            check("imem_we", k, {31'b0, we[k]}, {31'b0, exp_we[k]});
            check("err", k, {31'b0, err_o[k]}, {31'b0, exp_err[k]});
            check("full", k, {31'b0, full_o[k]}, {31'b0, cnt[k] == cap[k]});
            check("word_count", k, act_wc[k], cnt[k]);
            if (rst)
                check("reset_addr", k, act_addr[k], 32'h0);
            if (exp_we[k]) begin
                check("imem_addr", k, act_addr[k], exp_addr[k]);
                check("imem_wdata", k, wd[k], exp_wd[k]);
            end
            if (we[k])
                $display("dut%0d write addr=%0d data=%h count=%0d", k, act_addr[k], wd[k], act_wc[k]);
            if (err_o[k])
                $display("dut%0d err pulse count=%0d", k, act_wc[k]);
        end
    end

    task automatic send(input int op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [31:0] imm);
        in_valid = 1'b1;
        in_op = 5'(op); in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh; in_imm = imm;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    initial begin
        // Hand-computed words pin the model encoder.
        check("pin_add", 0, enc(0, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0), 32'h00221820);
        check("pin_ori", 0, enc(20, 5'd0, 5'd8, 5'd0, 5'd0, 32'h1234), 32'h34081234);
        check("pin_sll", 0, enc(10, 5'd7, 5'd5, 5'd4, 5'd2, 32'h0), 32'h00052080);
        check("pin_lui", 0, enc(26, 5'd0, 5'd9, 5'd0, 5'd0, 32'hDEAD), 32'h3C09DEAD);
        check("pin_li_ori", 0, enc(20, 5'd9, 5'd9, 5'd0, 5'd0, 32'hBEEF), 32'h3529BEEF);
        check("pin_j", 0, enc(29, 5'd0, 5'd0, 5'd0, 5'd0, 32'h40), 32'h08000040);
        check("pin_jr", 0, enc(16, 5'd31, 5'd2, 5'd3, 5'd4, 32'h0), 32'h03E00008);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(1);

        send(0, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0);                 // ADD
        idle(1);
        do_clear();
        send(20, 5'd0, 5'd8, 5'd0, 5'd0, 32'h1234);             // ORI
        send(10, 5'd7, 5'd5, 5'd4, 5'd2, 32'h0);                // SLL, rs forced 0
        idle(1);
        do_clear();
        send(30, 5'd0, 5'd9, 5'd0, 5'd0, 32'hDEADBEEF);         // LI
        send(0, 5'd1, 5'd1, 5'd1, 5'd0, 32'h0);                 // dropped on big during EMIT2
        idle(2);
        do_clear();
        send(29, 5'd0, 5'd0, 5'd0, 5'd0, 32'h40);               // J
        send(31, 5'd1, 5'd2, 5'd3, 5'd4, 32'h0);                // reserved
        idle(1);

        do_clear();
        for (int i = 0; i < 5; i++)
            send(1, 5'(i), 5'(i + 1), 5'(i + 2), 5'd0, 32'h0);  // ADDU fill; 5th blocked on small
        idle(1);
        do_clear();
        send(1, 5'd3, 5'd4, 5'd5, 5'd0, 32'h0);
        idle(1);

        do_clear();
        for (int i = 0; i < 3; i++)
            send(1, 5'(i), 5'd2, 5'd3, 5'd0, 32'h0);
        send(30, 5'd0, 5'd10, 5'd0, 5'd0, 32'h12345678);        // LI with one free word on small
        idle(2);

        do_clear();
        send(30, 5'd0, 5'd11, 5'd0, 5'd0, 32'h0000ABCD);        // LI then clear in EMIT2
        do_clear();
        idle(2);

        do_clear();
        for (int op = 0; op < 32; op++)
            send(op, 5'(op), 5'(op + 1), 5'(op + 2), 5'(op + 3),
                 {5'(op), 5'(op + 7), 5'(op + 13), 5'(op + 21), 12'hA5C});
        idle(2);

        do_clear();
        send(30, 5'd0, 5'd12, 5'd0, 5'd0, 32'hCAFEF00D);        // LI, rst in LUI cycle
        rst = 1'b1;
        #2;
        check("rst_mid_li_we", 0, {31'b0, we[0]}, 32'h0);
        check("rst_mid_li_count", 0, act_wc[0], 32'h0);
        check("rst_mid_li_wdata", 0, wd[0], 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
